// File: rtl/mul_result_checker_if.sv
// Stimulus/result bundle between the multiplier test stream and the result checker.
// The master side drives operands, valid and the product under test; the checker is the slave.
interface mul_result_checker_if #(
  parameter int NBIT_A = 12,
  parameter int NBIT_B = 12,
  parameter int NBIT_P = 22,
  parameter int CNTW   = 8
);
  logic                     VIN;
  logic signed [NBIT_A-1:0] A_IN;
  logic signed [NBIT_B-1:0] B_IN;
  logic        [NBIT_P-1:0] DIN;
  logic                     VOUT;
  logic                     MISMATCH;
  logic        [CNTW-1:0]   SAMP_CNT;
  logic        [CNTW-1:0]   ERR_CNT;
  logic        [CNTW-1:0]   FIRST_ERR;
  logic                     PASS;
  logic                     END_SIM;

  modport master (
    output VIN, A_IN, B_IN, DIN,
    input  VOUT, MISMATCH, SAMP_CNT, ERR_CNT, FIRST_ERR, PASS, END_SIM
  );

  modport slave (
    input  VIN, A_IN, B_IN, DIN,
    output VOUT, MISMATCH, SAMP_CNT, ERR_CNT, FIRST_ERR, PASS, END_SIM
  );
endinterface

// File: rtl/mul_result_checker.sv
// Receiving end of the multiplier test stream: realigns operands to the multiplier latency,
// checks each product against a golden signed product, counts results and raises END_SIM.
module mul_result_checker #(
  parameter int NBIT_A = 12,
  parameter int NBIT_B = 12,
  parameter int NBIT_P = 22,
  parameter int LAT    = 0,
  parameter int NSAMP  = 31,
  parameter int CNTW   = 8
) (
  input logic                CLK,
  input logic                RST_n,
  mul_result_checker_if.slave bus
);

  localparam int NBIT_AB = NBIT_A + NBIT_B;
  localparam logic [CNTW-1:0] NSAMP_C = CNTW'(NSAMP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (NSAMP >= (1 << CNTW)) begin : g_bad_nsamp
    $error("mul_result_checker: NSAMP must be < 2**CNTW");
  end
  if (LAT < 0 || LAT > 4) begin : g_bad_lat
    $error("mul_result_checker: LAT must be in 0..4");
  end

  // Full-width product first so most-negative x most-negative survives, then keep the LSBs.
  function automatic logic [NBIT_P-1:0] golden(input logic signed [NBIT_A-1:0] a,
                                               input logic signed [NBIT_B-1:0] b);
    logic signed [NBIT_AB-1:0] p;
    p = NBIT_AB'(a) * NBIT_AB'(b);
    return p[NBIT_P-1:0];
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == '1) ? c : c + CNTW'(1);
  endfunction

  logic signed [NBIT_A-1:0] a_d;
  logic signed [NBIT_B-1:0] b_d;
  logic                     v_d;

  // Alignment stage: free-running delay line, stage k holds inputs from k+1 clocks ago
  if (LAT == 0) begin : g_nodly
    assign a_d = bus.A_IN;
    assign b_d = bus.B_IN;
    assign v_d = bus.VIN;
  end else begin : g_dly
    logic signed [NBIT_A-1:0] a_sr [LAT];
    logic signed [NBIT_B-1:0] b_sr [LAT];
    logic                     v_sr [LAT];

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        for (int k = 0; k < LAT; k++) begin
          a_sr[k] <= '0;
          b_sr[k] <= '0;
          v_sr[k] <= 1'b0;
        end
      end else begin
        a_sr[0] <= bus.A_IN;
        b_sr[0] <= bus.B_IN;
        v_sr[0] <= bus.VIN;
        for (int k = 1; k < LAT; k++) begin
          a_sr[k] <= a_sr[k-1];
          b_sr[k] <= b_sr[k-1];
          v_sr[k] <= v_sr[k-1];
        end
      end
    end

    assign a_d = a_sr[LAT-1];
    assign b_d = b_sr[LAT-1];
    assign v_d = v_sr[LAT-1];
  end

  state_t          state, state_nxt;
  logic            cmp, err;
  logic [CNTW-1:0] samp_cnt, err_cnt, first_err, samp_inc;
  logic            vout_r, mism_r;

  assign samp_inc = samp_cnt + CNTW'(1);
  assign err      = (bus.DIN != golden(a_d, b_d));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // IDLE compares the first valid too, so no sample is lost on the IDLE->RUN transition.
  always_comb begin
    state_nxt = state;
    cmp       = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (v_d) begin
          cmp       = 1'b1;
          state_nxt = (samp_inc == NSAMP_C) ? DONE : RUN;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare stage: registered result pulses and counters
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vout_r    <= 1'b0;
      mism_r    <= 1'b0;
      samp_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      vout_r <= cmp;
      mism_r <= cmp && err;
      if (cmp) begin
        samp_cnt <= samp_inc;
        if (err) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) first_err <= samp_inc;
        end
      end
    end
  end

  assign bus.VOUT      = vout_r;
  assign bus.MISMATCH  = mism_r;
  assign bus.SAMP_CNT  = samp_cnt;
  assign bus.ERR_CNT   = err_cnt;
  assign bus.FIRST_ERR = first_err;
  assign bus.END_SIM   = (state == DONE);
  assign bus.PASS      = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_mul_result_checker.sv
// Bench for mul_result_checker: a LAT=0 and a LAT=2 instance driven by directed and random
// operand streams, checked every cycle against a queue-based reference model.
module tb_mul_result_checker;
  localparam int NA = 12;
  localparam int NB = 12;
  localparam int NP = 22;
  localparam int NS = 31;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  mul_result_checker_if #(.NBIT_A(NA), .NBIT_B(NB), .NBIT_P(NP), .CNTW(CW)) bus0 ();
  mul_result_checker_if #(.NBIT_A(NA), .NBIT_B(NB), .NBIT_P(NP), .CNTW(CW)) bus2 ();

  mul_result_checker #(.NBIT_A(NA), .NBIT_B(NB), .NBIT_P(NP), .LAT(0), .NSAMP(NS), .CNTW(CW))
    dut0 (.CLK(CLK), .RST_n(RST_n), .bus(bus0));
  mul_result_checker #(.NBIT_A(NA), .NBIT_B(NB), .NBIT_P(NP), .LAT(2), .NSAMP(NS), .CNTW(CW))
    dut2 (.CLK(CLK), .RST_n(RST_n), .bus(bus2));

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {bit v; int a; int b;} ent_t;
  ent_t h0[$];
  ent_t h2[$];
  int   m_samp[2];
  int   m_err[2];
  int   m_first[2];
  bit   m_done[2];

  function automatic longint golden(int a, int b);
    return (longint'(a) * longint'(b)) & ((longint'(1) <<< NP) - 1);
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, longint exp);
    n_vec++;
    assert (obs === 64'(exp)) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(int d, string pre, bit ev, bit em);
    logic vo, mm, es, ps;
    logic [CW-1:0] sc, ec, fe;
    int i;
    i = (d == 0) ? 0 : 1;
    if (d == 0) begin
      vo = bus0.VOUT; mm = bus0.MISMATCH; es = bus0.END_SIM; ps = bus0.PASS;
      sc = bus0.SAMP_CNT; ec = bus0.ERR_CNT; fe = bus0.FIRST_ERR;
    end else begin
      vo = bus2.VOUT; mm = bus2.MISMATCH; es = bus2.END_SIM; ps = bus2.PASS;
      sc = bus2.SAMP_CNT; ec = bus2.ERR_CNT; fe = bus2.FIRST_ERR;
    end
    chk({pre, ".vout"},      64'(vo), longint'(ev));
    chk({pre, ".mismatch"},  64'(mm), longint'(em));
    chk({pre, ".samp_cnt"},  64'(sc), longint'(m_samp[i]));
    chk({pre, ".err_cnt"},   64'(ec), longint'(m_err[i]));
    chk({pre, ".first_err"}, 64'(fe), longint'(m_first[i]));
    chk({pre, ".end_sim"},   64'(es), longint'(m_done[i]));
    chk({pre, ".pass"},      64'(ps), longint'(m_done[i] && m_err[i] == 0));
  endtask

  task automatic model_reset();
    h0.delete();
    h2.delete();
    for (int i = 0; i < 2; i++) begin
      m_samp[i] = 0; m_err[i] = 0; m_first[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  // One clock on instance d (0 or 2); the product under test is derived from the operands
  // that reach the compare point this cycle, corrupted by one LSB when bad is set.
  task automatic step(int d, bit v, int a, int b, bit bad, string tag);
    ent_t cur, e;
    bit vd, ev, em;
    int i, lat;
    longint din;
    i = (d == 0) ? 0 : 1;
    lat = (d == 0) ? 0 : 2;
    vd = 1'b0; ev = 1'b0; em = 1'b0;
    e.v = 1'b0; e.a = 0; e.b = 0;
    cur.v = v; cur.a = a; cur.b = b;
    if (RST_n) begin
      if (d == 0) begin
        h0.push_back(cur);
        if (h0.size() > lat) e = h0[h0.size() - 1 - lat];
        if (h0.size() > lat + 1) h0.pop_front();
      end else begin
        h2.push_back(cur);
        if (h2.size() > lat) e = h2[h2.size() - 1 - lat];
        if (h2.size() > lat + 1) h2.pop_front();
      end
      vd = e.v;
    end
    if (vd) din = golden(e.a, e.b);
    else    din = longint'($urandom) & ((longint'(1) <<< NP) - 1);
    if (vd && bad) din = (din + 1) & ((longint'(1) <<< NP) - 1);
    if (d == 0) begin
      bus0.VIN = v; bus0.A_IN = NA'(a); bus0.B_IN = NB'(b); bus0.DIN = NP'(din);
      bus2.VIN = 1'b0;
    end else begin
      bus2.VIN = v; bus2.A_IN = NA'(a); bus2.B_IN = NB'(b); bus2.DIN = NP'(din);
      bus0.VIN = 1'b0;
    end
    @(posedge CLK);
    #1;
    if (RST_n && vd && !m_done[i]) begin
      ev = 1'b1;
      m_samp[i]++;
      em = (din != golden(e.a, e.b));
      if (em) begin
        if (m_err[i] == 0) m_first[i] = m_samp[i];
        if (m_err[i] < 255) m_err[i]++;
      end
      if (m_samp[i] == NS) m_done[i] = 1'b1;
    end
    chk_outs(d, tag, ev, em);
  endtask

  task automatic do_reset(string tag);
    bus0.VIN = 1'b0;
    bus2.VIN = 1'b0;
    RST_n = 1'b0;
    #1;
    model_reset();
    chk_outs(0, {tag, ".d0"}, 1'b0, 1'b0);
    chk_outs(2, {tag, ".d2"}, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  initial begin
    int a, b, guard;
    bus0.VIN = 1'b0; bus0.A_IN = '0; bus0.B_IN = '0; bus0.DIN = '0;
    bus2.VIN = 1'b0; bus2.A_IN = '0; bus2.B_IN = '0; bus2.DIN = '0;
    RST_n = 1'b0;
    model_reset();

    // Reset held with VIN toggling, then released with no valid yet
    for (int i = 0; i < 4; i++) step(0, 1'(i % 2), i + 1, i + 2, 1'b0, "rst_hold");
    RST_n = 1'b1;
    for (int i = 0; i < 2; i++) step(0, 1'b0, 0, 0, 1'b0, "rst_rel");

    // LAT=0: 31 correct pairs A=i, B=-i with one gap, then valids after DONE
    for (int i = 1; i <= NS; i++) begin
      if (i == 16) step(0, 1'b0, 0, 0, 1'b0, "run_a_gap");
      step(0, 1'b1, i, -i, 1'b0, "run_a");
    end
    for (int i = 0; i < 3; i++) step(0, 1'b1, 5, 7, 1'b0, "run_a_done");

    // Bad product on sample 5, most-negative squared on sample 7
    do_reset("rst_b");
    for (int i = 1; i <= NS; i++) begin
      if (i == 5)      step(0, 1'b1, 3, 4, 1'b1, "run_b_bad");
      else if (i == 7) step(0, 1'b1, -2048, -2048, 1'b0, "run_b_edge");
      else             step(0, 1'b1, rnd_op(), rnd_op(), 1'b0, "run_b");
    end
    step(0, 1'b0, 0, 0, 1'b0, "run_b_end");

    // Reset after 10 samples, then a fresh random run with gaps and sporadic bad products
    do_reset("rst_c");
    for (int i = 0; i < 10; i++) step(0, 1'b1, rnd_op(), rnd_op(), 1'b0, "run_c_pre");
    do_reset("rst_c_mid");
    guard = 0;
    while (!m_done[0] && guard < 300) begin
      step(0, 1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(),
           1'($urandom_range(0, 7) == 0), "run_c");
      guard++;
    end
    chk("run_c.completed", 64'(m_done[0]), 1);
    for (int i = 0; i < 2; i++) step(0, 1'b1, rnd_op(), rnd_op(), 1'b0, "run_c_done");

    // LAT=2: VIN pattern 1,0,1,1 gives three compares, each 3 clocks after its VIN
    do_reset("rst_d");
    step(2, 1'b1, 100, -7, 1'b0, "lat2_pat");
    step(2, 1'b0, 0, 0, 1'b0, "lat2_pat");
    step(2, 1'b1, -2048, -2048, 1'b0, "lat2_pat");
    step(2, 1'b1, 2047, -2048, 1'b0, "lat2_pat");
    for (int i = 0; i < 3; i++) step(2, 1'b0, 0, 0, 1'b0, "lat2_pat_tail");
    chk("lat2_pat.count", 64'(bus2.SAMP_CNT), 3);

    // In-flight operands are discarded by reset
    step(2, 1'b1, 9, 9, 1'b0, "lat2_flight");
    do_reset("rst_e");
    for (int i = 0; i < 3; i++) step(2, 1'b0, 0, 0, 1'b0, "lat2_flushed");

    // LAT=2 random run to DONE, then valids ignored
    guard = 0;
    while (!m_done[1] && guard < 300) begin
      a = rnd_op();
      b = rnd_op();
      step(2, 1'($urandom_range(0, 3) != 0), a, b, 1'($urandom_range(0, 9) == 0), "lat2_run");
      guard++;
    end
    chk("lat2_run.completed", 64'(m_done[1]), 1);
    for (int i = 0; i < 4; i++) step(2, 1'b1, rnd_op(), rnd_op(), 1'b0, "lat2_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
